// File: rtl/mdu_iter.sv
// mdu_iter: iterative unsigned multiply/divide unit for the multi-cycle CPU.
// Takes two register-file operands, runs DATA_WIDTH shift-add or
// restoring-divide iterations, and returns the result as a one-cycle
// register-file write pulse (wen/waddr/wdata) together with done.
// Optional feature macro: MDU_DIV_EN. When it is defined, the restoring
// divider is built. When it is undefined, DIVU/REMU skip CALC and return
// all ones one cycle after acceptance.
`timescale 1ns/1ps
module mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
`ifdef MDU_DIV_EN
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q;
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   mcand_q;
  logic [2*DATA_WIDTH-1:0] prod_q;

  logic                    accept;
  logic                    last_iter;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] prod_step;

`ifdef MDU_DIV_EN
  logic [DATA_WIDTH-1:0]   divisor_q;
  logic [DATA_WIDTH:0]     rem_q;
  logic [DATA_WIDTH-1:0]   quo_q;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH:0]     div_diff;
  logic                    div_ge;
  logic [DATA_WIDTH:0]     rem_step;
  logic [DATA_WIDTH-1:0]   quo_step;
`endif

  logic                    done_d;
  logic                    wen_d;
  logic [ADDR_WIDTH-1:0]   dst_d;
  logic [DATA_WIDTH-1:0]   res_d;

  logic                    done_q;
  logic                    wen_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  // One iteration of the datapath: shift-add multiply and restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*DATA_WIDTH-1:DATA_WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {mul_sum, prod_q[DATA_WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // Divisor 0 always "fits", so the quotient fills with ones and the
    // remainder ends up equal to the dividend without a special case.
    div_shift = {rem_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, divisor_q};
    div_ge    = (div_shift >= {1'b0, divisor_q});
    rem_step  = div_ge ? div_diff : div_shift;
    quo_step  = {quo_q[DATA_WIDTH-2:0], div_ge};
`endif
  end

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef MDU_DIV_EN
          state_d = S_CALC;
`else
          state_d = in_op[1] ? S_DONE : S_CALC;
`endif
        end
      end
      S_CALC:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture at acceptance and one iteration per CALC cycle.
  // NOTE: datapath registers are reset too; the unit is required to come
  // out of reset with every internal register cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
`ifdef MDU_DIV_EN
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
`endif
    end else if (accept) begin
      op_q      <= in_op;
      rd_q      <= in_rd;
      cnt_q     <= '0;
      mcand_q   <= in_src1;
      prod_q    <= {{DATA_WIDTH{1'b0}}, in_src2};
`ifdef MDU_DIV_EN
      divisor_q <= in_src2;
      rem_q     <= '0;
      quo_q     <= in_src1;
`endif
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + 1'b1;
`ifdef MDU_DIV_EN
      if (op_q[1]) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
      end else begin
        prod_q <= prod_step;
      end
`else
      prod_q <= prod_step;
`endif
    end
  end

  // Output decode: issue readiness and the values the DONE cycle will present.
  always_comb begin
    in_ready = (state_q == S_IDLE);
    done_d   = (state_d == S_DONE);
    // Straight from IDLE to DONE only happens for an undivided DIVU/REMU,
    // whose rd has not been captured yet.
    dst_d    = (state_q == S_IDLE) ? in_rd : rd_q;
    wen_d    = done_d && (dst_d != '0);
    res_d    = '1;
    if (state_q == S_CALC) begin
      case (op_q)
        OP_MUL:   res_d = prod_step[DATA_WIDTH-1:0];
        OP_MULHU: res_d = prod_step[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MDU_DIV_EN
        OP_DIVU:  res_d = quo_step;
        OP_REMU:  res_d = rem_step[DATA_WIDTH-1:0];
`endif
        default:  res_d = '1;
      endcase
    end
  end

  // Registered write port: pulses for the DONE cycle, address/data hold after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= done_d;
      wen_q  <= wen_d;
      if (done_d) begin
        waddr_q <= dst_d;
        wdata_q <= res_d;
      end
    end
  end

  assign done  = done_q;
  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized operations,
// compared with a plain-arithmetic reference model. Follows MDU_DIV_EN.
`timescale 1ns/1ps
module tb_mdu_iter;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_src1;
  logic [DW-1:0] in_src2;
  logic [AW-1:0] in_rd;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;

  mdu_iter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_src1  (in_src1),
    .in_src2  (in_src2),
    .in_rd    (in_rd),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, required end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain arithmetic.
  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (op)
      2'd0:    return p[DW-1:0];
      2'd1:    return p[2*DW-1:DW];
      2'd2:    return (!DIV_EN || b == 0) ? '1 : a / b;
      default: return !DIV_EN ? '1 : (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op);
    return (op[1] && !DIV_EN) ? 1 : DW + 1;
  endfunction

  // Issue one op in the current cycle (cycle 0) and check every cycle up to
  // the first cycle back in IDLE; returns positioned in that cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [AW-1:0] rd, input bit hold_busy);
    int            lat;
    logic [DW-1:0] exp;
    lat = latency(op);
    exp = model(op, a, b);
    check({tag, " ready_c0"}, in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_rd    = rd;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      in_valid = hold_busy;
      in_op    = 2'($urandom);
      in_src1  = $urandom;
      in_src2  = $urandom;
      in_rd    = AW'($urandom);
      if (c < lat) begin
        check($sformatf("%s done_c%0d", tag, c), done, 0);
        check($sformatf("%s wen_c%0d", tag, c), wen, 0);
        check($sformatf("%s ready_c%0d", tag, c), in_ready, 0);
        check($sformatf("%s waddr_hold_c%0d", tag, c), waddr, exp_waddr);
        check($sformatf("%s wdata_hold_c%0d", tag, c), wdata, exp_wdata);
      end else begin
        check({tag, " done"}, done, 1);
        check({tag, " wen"}, wen, (rd != 0));
        check({tag, " waddr"}, waddr, rd);
        check({tag, " wdata"}, wdata, exp);
        check({tag, " ready_done"}, in_ready, 0);
        exp_waddr = rd;
        exp_wdata = exp;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " done_after"}, done, 0);
    check({tag, " wen_after"}, wen, 0);
    check({tag, " ready_after"}, in_ready, 1);
    check({tag, " waddr_after"}, waddr, exp_waddr);
    check({tag, " wdata_after"}, wdata, exp_wdata);
  endtask

  initial begin
    logic [1:0]    r_op;
    logic [DW-1:0] r_a, r_b;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = '0;
    in_src1  = '0;
    in_src2  = '0;
    in_rd    = '0;
    exp_waddr = '0;
    exp_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", in_ready, 1);
    check("reset wen", wen, 0);
    check("reset done", done, 0);
    check("reset waddr", waddr, 0);
    check("reset wdata", wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op("mul_basic", 2'd0, 32'h0001_0003, 32'h0000_0005, 5'd7, 1'b0);
    run_op("mulhu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op("mul_max",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    run_op("divu",      2'd2, 32'd100, 32'd7, 5'd1, 1'b0);
    run_op("remu",      2'd3, 32'd100, 32'd7, 5'd2, 1'b0);
    run_op("divu_z",    2'd2, 32'd5, 32'd0, 5'd8, 1'b0);
    run_op("remu_z",    2'd3, 32'd5, 32'd0, 5'd9, 1'b0);
    run_op("mul_rd0",   2'd0, 32'd3, 32'd4, 5'd0, 1'b1);
    run_op("after_hold", 2'd1, 32'h8000_0000, 32'd6, 5'd31, 1'b0);
    run_op("divu_9_3",  2'd2, 32'd9, 32'd3, 5'd4, 1'b0);

    // Reset in cycle 10 of a long operation.
    check("rst_op ready_c0", in_ready, 1);
    in_valid = 1'b1;
    in_op    = DIV_EN ? 2'd2 : 2'd0;
    in_src1  = 32'd1234;
    in_src2  = 32'd11;
    in_rd    = 5'd12;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_mid ready", in_ready, 1);
    check("rst_mid wen", wen, 0);
    check("rst_mid done", done, 0);
    check("rst_mid waddr", waddr, 0);
    check("rst_mid wdata", wdata, 0);
    exp_waddr = '0;
    exp_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_quiet done_%0d", c), done, 0);
      check($sformatf("rst_quiet wen_%0d", c), wen, 0);
    end
    run_op("mul_2x2", 2'd0, 32'd2, 32'd2, 5'd5, 1'b0);

    // Randomized operations, including zero and small divisors.
    for (int i = 0; i < 20; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = '0;
        1:       r_b = 32'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), r_op, r_a, r_b, AW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the multi-cycle CPU. It consumes the two operands read out of the register file (rdata1/rdata2), computes an unsigned multiply or divide result over 32 iterations, and returns the result through a single-cycle write pulse on the register file write port (wen/waddr/wdata). The control FSM uses a valid/ready handshake on the issue side and stalls issue while busy.

## Interface
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.
- ADDR_WIDTH, 5, destination register index width.

- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  issue request; operands, op and rd are valid.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder).
- in_src1  input  DATA_WIDTH  operand A (multiplicand/dividend).
- in_src2  input  DATA_WIDTH  operand B (multiplier/divisor).
- in_rd  input  ADDR_WIDTH  destination register index.
- wen  output  1  register file write enable, one-cycle pulse.
- waddr  output  ADDR_WIDTH  destination index, the captured in_rd.
- wdata  output  DATA_WIDTH  result.
- done  output  1  completion pulse, high even when in_rd = 0.

## Operation
- FSM states: IDLE -> CALC -> DONE -> IDLE.
- IDLE: in_ready = 1. On in_valid && in_ready, capture in_op, in_src1, in_src2 and in_rd, clear the iteration counter, and go to CALC. Inputs may change freely after the capture edge.
- CALC: one bit per cycle for DATA_WIDTH cycles.
  - MUL/MULHU: shift-add into a 2*DATA_WIDTH-bit product register. MUL returns product[31:0]; MULHU returns product[63:32].
  - DIVU/REMU: restoring division, one subtract-compare per cycle, using a DATA_WIDTH+1-bit partial remainder.
  - When the counter reaches DATA_WIDTH-1, go to DONE.
- DONE: done = 1, waddr = captured rd, wdata = result, and wen = 1 only if the captured rd != 0. Next state is IDLE.
- Divide by zero needs no special case and is not trapped: DIVU returns all ones and REMU returns the dividend.
- All arithmetic is unsigned and modulo 2^DATA_WIDTH; no overflow flag.
- Issue is blocking: in_valid asserted outside IDLE is ignored and is not queued.
- Reset at any point, including mid-CALC, returns the FSM to IDLE and discards the in-flight operation; no write is produced.

## Timing
- Reset values: in_ready = 1, wen = 0, done = 0, waddr = 0, wdata = 0. All internal registers are cleared.
- Cycle 0 is the acceptance cycle. CALC spans cycles 1..DATA_WIDTH (1..32). DONE is cycle 33. In cycle 34 the unit is in IDLE with in_ready = 1.
- Fixed latency: 33 cycles from acceptance to the write pulse. Peak throughput is one operation per 34 cycles.
- wen, waddr, wdata and done are registered outputs and are stable for the whole DONE cycle. Outside DONE, wen = 0 and done = 0; waddr and wdata hold their last values.
- The write lands in the register file at the rising edge that ends cycle 33. A consumer reading that register sees the new value from cycle 34 onward.

## Configuration
- MDU_DIV_EN defined: full behaviour as above.
- MDU_DIV_EN undefined: no divider datapath is synthesized.
  - DIVU and REMU are still accepted but skip CALC: IDLE -> DONE -> IDLE.
  - They produce wdata = all ones with done, and wen under the same rd != 0 rule, in cycle 1.
  - MUL and MULHU are unchanged.

## Test plan
- MUL 0x0001_0003 * 0x0000_0005, rd = 7 -> in cycle 33: wen = 1, waddr = 7, wdata = 0x0005_000F, done = 1. In cycle 34: in_ready = 1.
- MULHU 0xFFFF_FFFF * 0xFFFF_FFFF, rd = 3 -> wdata = 0xFFFF_FFFE in cycle 33. MUL on the same operands -> wdata = 0x0000_0001.
- DIVU 100 / 7 -> wdata = 14. REMU 100 % 7 -> wdata = 2. DIVU 5 / 0 -> wdata = 0xFFFF_FFFF. REMU 5 % 0 -> wdata = 5.
- MUL 3 * 4 with rd = 0 -> done = 1 in cycle 33 and wen = 0 throughout. A second in_valid held high during CALC is not accepted until cycle 34.
- Assert rst in cycle 10 of a DIVU -> in_ready = 1 and wen = 0 immediately. No done pulse appears in the following 40 cycles. A fresh MUL 2 * 2 afterwards returns 4 with normal latency.
- MDU_DIV_EN undefined: DIVU 9 / 3, rd = 4 -> wen = 1, waddr = 4, wdata = 0xFFFF_FFFF in cycle 1. in_ready = 1 in cycle 2.
